intersection_sched: RTL and testbench

INTERSECTION_SCHED -- requirements
Module: intersection_sched

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/phase_timer.sv | 27 ++
 rtl/intersection_sched.sv | 141 ++++++++++++++
 tb/tb_intersection_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared constants, state encoding and next-phase search for
// the four-way intersection scheduler.
package traffic_pkg;

    localparam int NUM_PHASES        = 4;
    localparam int PH_W              = 2;
    localparam int TIME_W            = 4;
    localparam int YELLOW_TIME_DEF   = 3;
    localparam int ALLRED_TIME_DEF   = 1;
    localparam int DEFAULT_GREEN_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_ALL_RED = 2'd3
    } state_t;

    // Round-robin search starting at cur+1 and wrapping back to cur.
    // Returns {found, phase}. Walks from farthest to nearest so the nearest
    // enabled phase is the last one written.
    function automatic logic [PH_W:0] pick_next(input logic [PH_W-1:0]       cur,
                                                input logic [NUM_PHASES-1:0] en);
        logic [PH_W-1:0] p;
        pick_next = '0;
        for (int i = NUM_PHASES; i >= 1; i--) begin
            p = cur + PH_W'(i);
            if (en[p]) pick_next = {1'b1, p};
        end
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down counter advanced only by the 1 Hz tick.
//   clk, rst      clock, async active-low reset
//   tick          one-clk enable pulse
//   load/load_val load wins over tick, so a tick on the load clk is ignored
//   count         current remaining ticks
//   done          count==1 on a tick: the state expires at this clk
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     count <= '0;
        else if (load)                count <= load_val;
        else if (tick && count != '0) count <= count - 1'b1;
    end

    assign done = tick && (count == W'(1));

endmodule

// File: rtl/intersection_sched.sv
// intersection_sched: four-phase traffic light sequencer with per-phase
// configurable green time and pedestrian walk latches.
//   clk, rst               clock, async active-low reset
//   tick                   1 Hz enable pulse (one clk wide)
//   run                    1 = sequence, 0 = park in all-red (via yellow)
//   cfg_valid/cfg_ready    green-time write handshake (ready in IDLE/ALL_RED)
//   cfg_phase/cfg_time     phase to configure / green ticks (0 disables)
//   ped_req                per-phase pedestrian request
//   green/yellow/red       per-phase lamps, exactly one lit per phase
//   ped_walk               walk for the phase currently green
//   phase/state            current phase / FSM state
import traffic_pkg::*;

module intersection_sched #(
    parameter int YELLOW_TIME   = YELLOW_TIME_DEF,
    parameter int ALLRED_TIME   = ALLRED_TIME_DEF,
    parameter int DEFAULT_GREEN = DEFAULT_GREEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  run,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [PH_W-1:0]       cfg_phase,
    input  logic [TIME_W-1:0]     cfg_time,
    input  logic [NUM_PHASES-1:0] ped_req,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic [NUM_PHASES-1:0] ped_walk,
    output logic [PH_W-1:0]       phase,
    output logic [1:0]            state
);

    state_t                               state_q, state_d;
    logic [PH_W-1:0]                      phase_q, phase_d;
    logic [NUM_PHASES-1:0][TIME_W-1:0]    green_time, gt_eff;
    logic [NUM_PHASES-1:0]                gt_en, pending, grn_mask;
    logic                                 cfg_xfer, enter_green, load, done;
    logic [TIME_W-1:0]                    load_val, count;
    logic [PH_W:0]                        pick;

    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_ALL_RED);
    assign cfg_xfer  = cfg_valid && cfg_ready;

    // A write landing on the ALL_RED expiry clk must already steer the
    // phase search and the green load, so look through the write port.
    always_comb begin
        gt_eff = green_time;
        if (cfg_xfer) gt_eff[cfg_phase] = cfg_time;
    end

    for (genvar i = 0; i < NUM_PHASES; i++) begin : g_en
        assign gt_en[i] = |gt_eff[i];
    end

    assign pick = pick_next(phase_q, gt_en);

    phase_timer #(.W(TIME_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .done     (done)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        load        = 1'b0;
        load_val    = '0;
        enter_green = 1'b0;
        case (state_q)
            ST_IDLE: if (run) begin
                state_d  = ST_ALL_RED;
                load     = 1'b1;
                load_val = TIME_W'(ALLRED_TIME);
                // search starts at phase_q+1, so park on the last phase
                phase_d  = PH_W'(NUM_PHASES - 1);
            end
            ST_GREEN: if (!run || done) begin
                state_d  = ST_YELLOW;
                load     = 1'b1;
                load_val = TIME_W'(YELLOW_TIME);
            end
            ST_YELLOW: if (done) begin
                state_d  = ST_ALL_RED;
                load     = 1'b1;
                load_val = TIME_W'(ALLRED_TIME);
            end
            ST_ALL_RED: if (done) begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (pick[PH_W]) begin
                    state_d     = ST_GREEN;
                    phase_d     = pick[PH_W-1:0];
                    load        = 1'b1;
                    load_val    = gt_eff[pick[PH_W-1:0]];
                    enter_green = 1'b1;
                end else begin
                    load     = 1'b1;
                    load_val = TIME_W'(ALLRED_TIME);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grn_mask = enter_green ? (NUM_PHASES'(1) << phase_d) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            pending  <= '0;
            ped_walk <= '0;
            for (int i = 0; i < NUM_PHASES; i++) green_time[i] <= TIME_W'(DEFAULT_GREEN);
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (cfg_xfer) green_time[cfg_phase] <= cfg_time;
            // a request arriving on the entry clk survives for the next green
            pending <= (pending & ~grn_mask) | ped_req;
            if (enter_green)             ped_walk <= pending & grn_mask;
            else if (state_d != ST_GREEN) ped_walk <= '0;
        end
    end

    for (genvar i = 0; i < NUM_PHASES; i++) begin : g_lamp
        assign green[i]  = (state_q == ST_GREEN)  && (phase_q == PH_W'(i));
        assign yellow[i] = (state_q == ST_YELLOW) && (phase_q == PH_W'(i));
        assign red[i]    = !(green[i] || yellow[i]);
    end

    assign phase = phase_q;
    assign state = state_q;

endmodule

// File: tb/tb_intersection_sched.sv
module tb_intersection_sched;
    localparam int YT = 3, AT = 1, DG = 10;

    logic       clk = 0, rst = 1, tick = 0, run = 0, cfg_valid = 0;
    logic [1:0] cfg_phase = 0;
    logic [3:0] cfg_time = 0, ped_req = 0;
    logic       cfg_ready;
    logic [3:0] green, yellow, red, ped_walk;
    logic [1:0] phase, state;

    always #5 clk = ~clk;

    intersection_sched #(.YELLOW_TIME(YT), .ALLRED_TIME(AT), .DEFAULT_GREEN(DG)) dut (
        .clk(clk), .rst(rst), .tick(tick), .run(run),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_phase(cfg_phase), .cfg_time(cfg_time),
        .ped_req(ped_req), .green(green), .yellow(yellow), .red(red),
        .ped_walk(ped_walk), .phase(phase), .state(state)
    );

    int total = 0, bad = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // states: 0 idle, 1 green, 2 yellow, 3 all-red; m_left = ticks remaining
    int         m_st, m_left, m_ph, np;
    logic [3:0] m_gt [4];
    logic [3:0] m_pend, m_walk;
    bit         expire;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st = 0; m_left = 0; m_ph = 0; m_pend = 0; m_walk = 0;
            for (int i = 0; i < 4; i++) m_gt[i] = 4'(DG);
        end else begin
            if (cfg_valid && (m_st == 0 || m_st == 3)) m_gt[cfg_phase] = cfg_time;
            expire = tick && (m_left == 1);
            case (m_st)
                0: if (run) begin m_st = 3; m_left = AT; m_ph = -1; end
                1: if (!run || expire) begin m_st = 2; m_left = YT; end
                   else if (tick) m_left--;
                2: if (expire) begin m_st = 3; m_left = AT; end
                   else if (tick) m_left--;
                default: if (expire) begin
                    if (!run) begin m_st = 0; m_left = 0; end
                    else begin
                        np = -1;
                        for (int k = 1; k <= 4; k++)
                            if (np < 0 && m_gt[(m_ph + k) % 4] != 0) np = (m_ph + k) % 4;
                        if (np >= 0) begin
                            m_st = 1; m_ph = np; m_left = m_gt[np];
                            m_walk = 0; m_walk[np] = m_pend[np]; m_pend[np] = 1'b0;
                        end else m_left = AT;
                    end
                end else if (tick) m_left--;
            endcase
            m_pend = m_pend | ped_req;
            if (m_st != 1) m_walk = 0;
        end
    end

    // ---------------- compare process ----------------
    logic [3:0] eg, ey;
    always @(negedge clk) begin
        eg = (m_st == 1) ? (4'b0001 << m_ph) : 4'b0000;
        ey = (m_st == 2) ? (4'b0001 << m_ph) : 4'b0000;
        check("lamps",     {green, yellow, red}, {eg, ey, ~(eg | ey)});
        check("ped_walk",  ped_walk, m_walk);
        check("state",     state, m_st);
        check("cfg_ready", cfg_ready, (m_st == 0 || m_st == 3));
        if (m_st == 1 || m_st == 2) check("phase", phase, m_ph);
    end

    // ---------------- monitors for literal pins ----------------
    int gtp [4];
    int yt_cnt, at_cnt, green_on;
    int seq [$];
    logic [1:0] prev_state = 0;

    always @(posedge clk) if (rst && tick) begin
        case (state)
            2'd1: gtp[phase]++;
            2'd2: yt_cnt++;
            2'd3: at_cnt++;
            default: ;
        endcase
    end

    always @(negedge clk) begin
        if (state == 2'd1 && prev_state != 2'd1) seq.push_back(int'(phase));
        if (green != 0) green_on++;
        prev_state = state;
    end

    task automatic clr_mon();
        for (int i = 0; i < 4; i++) gtp[i] = 0;
        yt_cnt = 0; at_cnt = 0; green_on = 0; seq.delete();
    endtask

    // ---------------- driver ----------------
    int tper = 0, cyc = 0;
    task automatic clk1();
        @(posedge clk); #1;
        cyc++;
        if (tper != 0) tick = (cyc % tper == 0);
    endtask

    task automatic do_reset();
        rst = 0; run = 0; cfg_valid = 0; ped_req = 0;
        clk1(); clk1();
        rst = 1;
        clr_mon();
    endtask

    initial begin
        #2 rst = 0;
        #1;
        check("rst_state",  state, 0);
        check("rst_phase",  phase, 0);
        check("rst_red",    red, 4'b1111);
        check("rst_green",  green, 0);
        check("rst_yellow", yellow, 0);
        check("rst_walk",   ped_walk, 0);
        check("rst_ready",  cfg_ready, 1);

        // basic sequence, tick every 10 clk
        tper = 10;
        do_reset();
        run = 1;
        for (int n = 0; n < 600 && green != 4'b0010; n++) clk1();
        check("a_reach_g1", green, 4'b0010);
        check("a_g0_ticks", gtp[0], 10);
        check("a_y_ticks",  yt_cnt, 3);
        check("a_ar_ticks", at_cnt, 2);
        check("a_first",    (seq.size() > 0) ? seq[0] : -1, 0);

        // phase 1 disabled, phase 2 short
        do_reset();
        cfg_valid = 1; cfg_phase = 1; cfg_time = 0; clk1();
        cfg_phase = 2; cfg_time = 4; clk1();
        cfg_valid = 0; tper = 2; run = 1;
        for (int n = 0; n < 1000 && seq.size() < 4; n++) clk1();
        check("b_len", seq.size(), 4);
        if (seq.size() >= 4) begin
            check("b_seq0", seq[0], 0);
            check("b_seq1", seq[1], 2);
            check("b_seq2", seq[2], 3);
            check("b_seq3", seq[3], 0);
        end
        check("b_g2_ticks", gtp[2], 4);

        // every phase disabled
        do_reset();
        cfg_valid = 1;
        for (int p = 0; p < 4; p++) begin cfg_phase = 2'(p); cfg_time = 0; clk1(); end
        cfg_valid = 0; run = 1;
        for (int n = 0; n < 200; n++) clk1();
        check("c_state",    state, 3);
        check("c_red",      red, 4'b1111);
        check("c_no_green", green_on, 0);

        // drop run mid-green
        do_reset();
        tper = 4; run = 1;
        for (int n = 0; n < 500 && !(state == 1 && gtp[0] == 2); n++) clk1();
        check("d_in_green", (state == 1 && gtp[0] == 2), 1);
        run = 0; yt_cnt = 0; at_cnt = 0;
        clk1();
        check("d_yellow_now", yellow, 4'b0001);
        for (int n = 0; n < 200 && state != 0; n++) clk1();
        check("d_idle",     state, 0);
        check("d_y_ticks",  yt_cnt, 3);
        check("d_ar_ticks", at_cnt, 1);
        green_on = 0;
        for (int n = 0; n < 100; n++) clk1();
        check("d_no_green", green_on, 0);

        // pedestrian latch
        do_reset();
        tper = 2; run = 1;
        for (int n = 0; n < 300 && !(state == 1 && phase == 0); n++) clk1();
        ped_req = 4'b0010; clk1(); ped_req = 0;
        for (int n = 0; n < 300 && !(state == 1 && phase == 1); n++) clk1();
        check("e_walk1", ped_walk, 4'b0010);
        ped_req = 4'b0010; clk1(); ped_req = 0;
        for (int n = 0; n < 300 && !(state == 1 && phase == 2); n++) clk1();
        check("e_walk_p2", ped_walk, 0);
        for (int n = 0; n < 300 && !(state == 1 && phase == 1); n++) clk1();
        check("e_walk2", ped_walk, 4'b0010);
        for (int n = 0; n < 300 && !(state == 1 && phase == 2); n++) clk1();
        for (int n = 0; n < 300 && !(state == 1 && phase == 1); n++) clk1();
        check("e_walk3", ped_walk, 0);

        // config refused in green, then async reset mid-green
        cfg_valid = 1; cfg_phase = phase; cfg_time = 4'd1;
        @(negedge clk);
        check("f_ready_green", cfg_ready, 0);
        clk1();
        cfg_valid = 0;
        #3 rst = 0;
        #1;
        check("f_async_red",   red, 4'b1111);
        check("f_async_green", green, 0);
        check("f_async_state", state, 0);
        clk1();
        rst = 1;

        // randomized soak against the model
        clr_mon();
        tper = 0; run = 1;
        for (int n = 0; n < 5000; n++) begin
            clk1();
            tick      = ($urandom_range(2, 0) == 0);
            if ($urandom_range(63, 0) == 0) run = ~run;
            cfg_valid = ($urandom_range(5, 0) == 0);
            cfg_phase = 2'($urandom_range(3, 0));
            cfg_time  = ($urandom_range(3, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 0));
            ped_req   = ($urandom_range(4, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'd0;
            if ($urandom_range(1499, 0) == 0) begin
                #2 rst = 0;
                #2 rst = 1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
